// File: rtl/jpeg_qnr_stage_if.sv
// Coefficient/table bus for the JPEG quantizer stage.
//   din/din_vld/dstrb       : signed 12-bit coefficient in zigzag order, valid, DC strobe
//   qt_we/qt_addr/qt_din    : reciprocal table write port (round(4096/Q), 13-bit)
//   dout/douten/dstrb_out   : signed 11-bit quantized coefficient, valid, DC strobe
// master drives the coefficient and table inputs; slave is the quantizer.
interface jpeg_qnr_stage_if;
  logic [11:0] din;
  logic        din_vld;
  logic        dstrb;
  logic        qt_we;
  logic [5:0]  qt_addr;
  logic [12:0] qt_din;
  logic [10:0] dout;
  logic        douten;
  logic        dstrb_out;

  modport master (
    output din, din_vld, dstrb, qt_we, qt_addr, qt_din,
    input  dout, douten, dstrb_out
  );

  modport slave (
    input  din, din_vld, dstrb, qt_we, qt_addr, qt_din,
    output dout, douten, dstrb_out
  );
endinterface

// File: rtl/jpeg_qnr_stage.sv
// JPEG quantizer: multiplies |din| by a per-coefficient reciprocal, rounds half away
// from zero, saturates to +/-1023 and restores the sign. Three-stage pipeline
// (operands, product, rounded result), one coefficient per clock.
// Ports:
//   clk  : clock, rising edge
//   rst  : asynchronous active-low reset (clears pipeline, counter and table)
//   ena  : pipeline enable; low freezes all pipeline state and the coefficient counter
//   bus  : coefficient in/out and table write port (slave side)
module jpeg_qnr_stage (
  input  logic             clk,
  input  logic             rst,
  input  logic             ena,
  jpeg_qnr_stage_if.slave  bus
);

  logic [12:0] qt_q [64];
  logic [12:0] qt_d [64];
  logic [5:0]  cnt_q, cnt_d;

  logic        s1_vld_q, s1_vld_d, s1_strb_q, s1_strb_d, s1_neg_q, s1_neg_d;
  logic [11:0] s1_abs_q, s1_abs_d;
  logic [12:0] s1_rcp_q, s1_rcp_d;

  logic        s2_vld_q, s2_vld_d, s2_strb_q, s2_strb_d, s2_neg_q, s2_neg_d;
  logic [24:0] s2_prod_q, s2_prod_d;

  logic [10:0] dout_q, dout_d;
  logic        douten_q, douten_d, dstrb_out_q, dstrb_out_d;

  logic        accept;
  logic [5:0]  rd_idx;
  logic [11:0] din_abs;
  logic [12:0] mag_full;
  logic [10:0] mag_sat;

  // Table write is independent of ena. The read below sees qt_q, so a same-cycle
  // write to the entry being read returns the old value.
  always_comb begin
    qt_d = qt_q;
    if (bus.qt_we) qt_d[bus.qt_addr] = bus.qt_din;
  end

  always_comb begin
    accept  = ena & bus.din_vld;
    rd_idx  = bus.dstrb ? 6'd0 : cnt_q;
    // -(-2048) is 2048, which still fits 12 bits unsigned
    din_abs = bus.din[11] ? (~bus.din + 12'd1) : bus.din;

    cnt_d     = cnt_q;
    s1_vld_d  = s1_vld_q;
    s1_strb_d = s1_strb_q;
    s1_neg_d  = s1_neg_q;
    s1_abs_d  = s1_abs_q;
    s1_rcp_d  = s1_rcp_q;
    s2_vld_d  = s2_vld_q;
    s2_strb_d = s2_strb_q;
    s2_neg_d  = s2_neg_q;
    s2_prod_d = s2_prod_q;
    dout_d      = dout_q;
    douten_d    = douten_q;
    dstrb_out_d = dstrb_out_q;

    // Max product 2048*8191 plus 2048 stays below 2^25.
    mag_full = 13'((s2_prod_q + 25'd2048) >> 12);
    mag_sat  = (mag_full > 13'd1023) ? 11'd1023 : {1'b0, mag_full[9:0]};

    if (ena) begin
      // Stage 1: operands
      s1_vld_d  = bus.din_vld;
      s1_strb_d = bus.din_vld & bus.dstrb;
      if (accept) begin
        cnt_d    = rd_idx + 6'd1;  // 63 -> 0 wraps naturally
        s1_neg_d = bus.din[11];
        s1_abs_d = din_abs;
        s1_rcp_d = qt_q[rd_idx];
      end
      // Stage 2: product
      s2_vld_d  = s1_vld_q;
      s2_strb_d = s1_strb_q;
      s2_neg_d  = s1_neg_q;
      s2_prod_d = 25'(s1_abs_q) * 25'(s1_rcp_q);
      // Stage 3: round, saturate, sign; dout holds across bubbles
      douten_d    = s2_vld_q;
      dstrb_out_d = s2_strb_q;
      if (s2_vld_q) dout_d = s2_neg_q ? (~mag_sat + 11'd1) : mag_sat;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 64; i++) qt_q[i] <= 13'h1000;
    end else begin
      qt_q <= qt_d;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q       <= '0;
      s1_vld_q    <= 1'b0;
      s1_strb_q   <= 1'b0;
      s1_neg_q    <= 1'b0;
      s1_abs_q    <= '0;
      s1_rcp_q    <= '0;
      s2_vld_q    <= 1'b0;
      s2_strb_q   <= 1'b0;
      s2_neg_q    <= 1'b0;
      s2_prod_q   <= '0;
      dout_q      <= '0;
      douten_q    <= 1'b0;
      dstrb_out_q <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      s1_vld_q    <= s1_vld_d;
      s1_strb_q   <= s1_strb_d;
      s1_neg_q    <= s1_neg_d;
      s1_abs_q    <= s1_abs_d;
      s1_rcp_q    <= s1_rcp_d;
      s2_vld_q    <= s2_vld_d;
      s2_strb_q   <= s2_strb_d;
      s2_neg_q    <= s2_neg_d;
      s2_prod_q   <= s2_prod_d;
      dout_q      <= dout_d;
      douten_q    <= douten_d;
      dstrb_out_q <= dstrb_out_d;
    end
  end

  assign bus.dout      = dout_q;
  assign bus.douten    = douten_q;
  assign bus.dstrb_out = dstrb_out_q;

endmodule

// File: tb/tb_jpeg_qnr_stage.sv
// Directed bench for jpeg_qnr_stage. Inputs change 1 time unit after the rising edge;
// outputs are sampled at the same point, so after tick() the outputs reflect that edge.
module tb_jpeg_qnr_stage;

  logic clk, rst, ena;
  int   n_cmp, n_bad;

  jpeg_qnr_stage_if bus ();

  jpeg_qnr_stage dut (
    .clk (clk),
    .rst (rst),
    .ena (ena),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic out(input string tag, input int en, input int st, input int val);
    chk({tag, ".douten"}, int'(bus.douten), en);
    chk({tag, ".dstrb_out"}, int'(bus.dstrb_out), st);
    chk({tag, ".dout"}, int'($signed(bus.dout)), val);
  endtask

  task automatic drv(input logic v, input logic s, input int d);
    bus.din_vld = v;
    bus.dstrb   = s;
    bus.din     = 12'(d);
  endtask

  task automatic wr(input logic we, input int a, input int v);
    bus.qt_we   = we;
    bus.qt_addr = 6'(a);
    bus.qt_din  = 13'(v);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int k, pos, ev;
    n_cmp = 0;
    n_bad = 0;
    clk = 1'b0;
    rst = 1'b0;
    ena = 1'b0;
    drv(1'b0, 1'b0, 0);
    // Write attempted during reset must be ignored (entry 0 stays identity).
    wr(1'b1, 0, 123);
    #12;
    out("reset", 0, 0, 0);
    tick();
    wr(1'b0, 0, 0);
    rst = 1'b1;
    ena = 1'b1;

    // Default table: 100 with DC strobe, then -37, three cycles latency.
    drv(1'b1, 1'b1, 100);  tick(); out("dflt.c1", 0, 0, 0);
    drv(1'b1, 1'b0, -37);  tick(); out("dflt.c2", 0, 0, 0);
    drv(1'b0, 1'b0, 0);    tick(); out("dflt.c3", 1, 1, 100);
    tick(); out("dflt.c4", 1, 0, -37);
    tick(); out("dflt.bubble", 0, 0, -37);

    // Entry 5 = 410; two blocks with -155 then +155 at position 5.
    wr(1'b1, 5, 410); tick(); wr(1'b0, 0, 0);
    for (int i = 0; i < 14; i++) begin
      if (i < 12) drv(1'b1, (i % 6) == 0, (i == 5) ? -155 : ((i == 11) ? 155 : 0));
      else drv(1'b0, 1'b0, 0);
      tick();
      k = i - 2;
      if (i < 2) out($sformatf("q410.fill%0d", i), 0, 0, -37);
      else out($sformatf("q410.s%0d", k), 1, int'((k % 6) == 0),
               (k == 5) ? -16 : ((k == 11) ? 16 : 0));
    end
    tick(); out("q410.idle", 0, 0, 16);

    // Saturation: entry 0 = 8191.
    wr(1'b1, 0, 8191); tick(); wr(1'b0, 0, 0);
    drv(1'b1, 1'b1, 2047);  tick(); out("sat.c1", 0, 0, 16);
    drv(1'b1, 1'b1, -2048); tick(); out("sat.c2", 0, 0, 16);
    drv(1'b0, 1'b0, 0);     tick(); out("sat.pos", 1, 1, 1023);
    tick(); out("sat.neg", 1, 1, -1023);
    tick(); out("sat.idle", 0, 0, -1023);

    // 130 samples of 10, dstrb only on the first. Entry 0 is rewritten to 2048 in the
    // same cycle sample 0 reads it, so sample 0 still uses 8191 -> 20; samples 64 and
    // 128 use 2048 -> 5; position 5 uses 410 -> 1; all others identity -> 10.
    for (int i = 0; i < 132; i++) begin
      if (i == 0) wr(1'b1, 0, 2048);
      if (i < 130) drv(1'b1, i == 0, 10);
      else drv(1'b0, 1'b0, 0);
      tick();
      wr(1'b0, 0, 0);
      if (i >= 2) begin
        k   = i - 2;
        pos = k % 64;
        ev  = (k == 0) ? 20 : ((pos == 0) ? 5 : ((pos == 5) ? 1 : 10));
        out($sformatf("wrap.s%0d", k), 1, int'(k == 0), ev);
      end
    end
    tick(); out("wrap.idle", 0, 0, 10);

    // Stall: ena=0 for 4 cycles with an output valid; garbage input must be ignored.
    drv(1'b1, 1'b1, 40); tick(); out("stall.c1", 0, 0, 10);
    drv(1'b1, 1'b0, 7);  tick(); out("stall.c2", 0, 0, 10);
    drv(1'b1, 1'b0, -9); tick(); out("stall.c3", 1, 1, 20);
    ena = 1'b0;
    drv(1'b1, 1'b1, 999);
    for (int i = 0; i < 4; i++) begin
      tick();
      out($sformatf("stall.frz%0d", i), 1, 1, 20);
    end
    ena = 1'b1;
    drv(1'b1, 1'b0, 3); tick(); out("stall.o1", 1, 0, 7);
    drv(1'b0, 1'b0, 0); tick(); out("stall.o2", 1, 0, -9);
    tick(); out("stall.o3", 1, 0, 3);
    tick(); out("stall.idle", 0, 0, 3);

    // Reset mid-burst: immediate clear, in-flight dropped, counter back to entry 0.
    drv(1'b1, 1'b1, 50); tick(); out("rst.c1", 0, 0, 3);
    drv(1'b1, 1'b0, 60); tick(); out("rst.c2", 0, 0, 3);
    drv(1'b1, 1'b0, 70); tick(); out("rst.c3", 1, 1, 25);
    drv(1'b1, 1'b0, 80);
    rst = 1'b0;
    #1; out("rst.async", 0, 0, 0);
    tick(); out("rst.held", 0, 0, 0);
    rst = 1'b1;
    drv(1'b0, 1'b0, 0);
    wr(1'b1, 0, 2048); tick(); out("rst.wr", 0, 0, 0);
    wr(1'b0, 0, 0);
    drv(1'b1, 1'b0, 80); tick(); out("rst.p1", 0, 0, 0);
    drv(1'b1, 1'b0, 80); tick(); out("rst.p2", 0, 0, 0);
    drv(1'b0, 1'b0, 0);  tick(); out("rst.e0", 1, 0, 40);
    tick(); out("rst.e1", 1, 0, 80);
    tick(); out("rst.idle", 0, 0, 80);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/jpeg_qnr_stage.md
JPEG_QNR_STAGE -- requirements
Module: jpeg_qnr_stage

Interface
REQ-001 SHALL have port clk, input, 1 bit: sole clock; all state updates on the rising edge.
REQ-002 SHALL have port rst, input, 1 bit: reset, asynchronous, active-low.
REQ-003 SHALL have port ena, input, 1 bit: pipeline enable; low freezes all pipeline state.
REQ-004 SHALL have port din, input, 12 bits: signed DCT coefficient, arriving in zigzag order from the zigzag stage.
REQ-005 SHALL have port din_vld, input, 1 bit: din valid.
REQ-006 SHALL have port dstrb, input, 1 bit: marks coefficient 0 (DC) of an 8x8 block; qualified by din_vld.
REQ-007 SHALL have port qt_we, input, 1 bit: reciprocal-table write enable.
REQ-008 SHALL have port qt_addr, input, 6 bits: table index, in zigzag order.
REQ-009 SHALL have port qt_din, input, 13 bits: unsigned reciprocal, round(4096/Q).
REQ-010 SHALL have port dout, output, 11 bits: signed quantized coefficient.
REQ-011 SHALL have port douten, output, 1 bit: dout valid.
REQ-012 SHALL have port dstrb_out, output, 1 bit: dout is coefficient 0 of a block.

Function
REQ-013 SHALL accept a sample when ena=1 and din_vld=1; no other condition accepts a sample.
REQ-014 SHALL keep a 6-bit coefficient counter cnt that selects the table entry for each accepted sample.
REQ-015 SHALL, for an accepted sample with dstrb=1, use entry 0 and set cnt to 1; otherwise use entry cnt and increment cnt.
REQ-016 SHALL wrap cnt from 63 to 0 without needing dstrb; dstrb mid-block SHALL restart at entry 0.
REQ-017 SHALL hold a 64 x 13-bit reciprocal table, written at qt_addr with qt_din when qt_we=1, independent of ena.
REQ-018 SHALL, when a write and a read hit the same entry in the same cycle, read the old value; the new value applies from the next cycle.
REQ-019 SHALL compute mag = (|din| * recip + 2048) >> 12 using a 25-bit unsigned intermediate.
REQ-020 SHALL output dout = -mag when din<0 and +mag otherwise, giving symmetric round-half-away-from-zero.
REQ-021 SHALL clip mag to 1023 before applying the sign; the output range is -1023..+1023 and -1024 is never produced.
REQ-022 SHALL use a three-stage pipeline: S1 registers din, sign and recip; S2 registers the product; S3 registers the rounded and saturated result.
REQ-023 SHALL assert douten exactly 3 enabled cycles after the accepted sample, and dstrb_out in the same cycle as that sample's douten.
REQ-024 SHALL, while ena=0, hold every pipeline register, cnt, dout, douten and dstrb_out; the latency count resumes when ena returns to 1.
REQ-025 SHALL propagate a bubble (din_vld=0 with ena=1) as douten=0; dout holds its last valid value during bubbles.
REQ-026 SHALL give back-to-back accepted samples back-to-back outputs, with a throughput of 1 coefficient per clock.

Reset
REQ-027 SHALL, while rst=0, force dout=0, douten=0, dstrb_out=0, cnt=0 and clear all pipeline valid and strobe bits, asynchronously.
REQ-028 SHALL reset every table entry to 13'h1000 (Q=1, identity).
REQ-029 SHALL, when reset is asserted mid-block, drop all in-flight samples; the first sample after release uses entry 0 even without dstrb.
REQ-030 SHALL ignore qt_we while rst=0.

Verification
REQ-031 SHALL check: assert rst=0 during a burst -> dout=0, douten=0, dstrb_out=0 immediately; after release, the next sample is quantized with entry 0.
REQ-032 SHALL check: default table, dstrb=1 with din=100, then din=-37 on consecutive cycles -> douten on cycles +3 and +4, with dout=100 (dstrb_out=1) then -37.
REQ-033 SHALL check: write entry 5 = 410, then send a block with din=-155 at position 5 -> dout=-16 ((155*410+2048)>>12=16); with din=+155 -> dout=+16.
REQ-034 SHALL check: entry 0 = 8191, din=2047 -> dout=1023; din=-2048 -> dout=-1023.
REQ-035 SHALL check: 130 consecutive samples with dstrb only on the first -> cnt wraps twice, and samples 64 and 128 use entry 0 with dstrb_out=0.
REQ-036 SHALL check: ena=0 for 4 cycles mid-burst -> outputs frozen, no sample lost or duplicated, and latency is 3 enabled cycles per sample.
